// File: rtl/wb_port_arbiter_pkg.sv
// ============================================================================
// Module : wb_port_arbiter_pkg
// Brief  : Shared widths and ROB age helpers for the writeback port arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package wb_port_arbiter_pkg;

  localparam int C_REQ_NUM  = 10;
  localparam int C_PORT_NUM = 6;
  localparam int C_IPRIDX_W = 7;
  localparam int C_ROBIDX_W = 7;
  localparam int C_DATA_W   = 64;

  // The flag bit flips on each ROB wrap, so a differing flag inverts the index order.
  function automatic logic rob_younger(input logic        a_flag,
                                       input logic [31:0] a_idx,
                                       input logic        b_flag,
                                       input logic [31:0] b_idx);
    if (a_flag == b_flag) begin
      return a_idx > b_idx;
    end
    return a_idx < b_idx;
  endfunction

  function automatic logic rob_killed(input logic        c_flag,
                                      input logic [31:0] c_idx,
                                      input logic        s_flag,
                                      input logic [31:0] s_idx);
    return rob_younger(c_flag, c_idx, s_flag, s_idx) ||
           ((c_flag == s_flag) && (c_idx == s_idx));
  endfunction

endpackage

`default_nettype wire

// File: rtl/wb_port_arbiter_picker.sv
// ============================================================================
// Module : wbarb_picker
// Brief  : Combinational multi-grant round-robin; held candidates beat live ones.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wbarb_picker #(
  parameter int REQ_NUM  = 10,
  parameter int PORT_NUM = 6,
  parameter int SRC_W    = 4
) (
  input  logic [REQ_NUM-1:0]                i_req,
  input  logic [REQ_NUM-1:0]                i_held,
  input  logic [SRC_W-1:0]                  i_rr_ptr,
  output logic [PORT_NUM-1:0]               o_port_vld,
  output logic [PORT_NUM-1:0][SRC_W-1:0]    o_port_id,
  output logic [REQ_NUM-1:0]                o_granted,
  output logic                              o_any_grant,
  output logic [SRC_W-1:0]                  o_last_id
);

  always_comb begin
    int                 cnt;
    logic [SRC_W:0]     sum;
    logic [SRC_W-1:0]   idx;
    o_port_vld  = '0;
    o_port_id   = '0;
    o_granted   = '0;
    o_any_grant = 1'b0;
    o_last_id   = '0;
    cnt         = 0;
    sum         = '0;
    idx         = '0;
    // Pass 0 scans held candidates, pass 1 live ones, both from the same pointer.
    for (int pass = 0; pass < 2; pass++) begin
      for (int j = 0; j < REQ_NUM; j++) begin
        sum = {1'b0, i_rr_ptr} + (SRC_W+1)'(j);
        if (sum >= (SRC_W+1)'(REQ_NUM)) begin
          sum = sum - (SRC_W+1)'(REQ_NUM);
        end
        idx = sum[SRC_W-1:0];
        if (i_req[idx] && (i_held[idx] == (pass == 0)) && (cnt < PORT_NUM)) begin
          for (int k = 0; k < PORT_NUM; k++) begin
            if (k == cnt) begin
              o_port_vld[k] = 1'b1;
              o_port_id[k]  = idx;
            end
          end
          o_granted[idx] = 1'b1;
          o_any_grant    = 1'b1;
          o_last_id      = idx;
          cnt            = cnt + 1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/wb_port_arbiter.sv
// ============================================================================
// Module : wb_port_arbiter
// Brief  : Shares regfile write ports among FU results with hold slots and squash.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int  REQ_NUM  = C_REQ_NUM,
  parameter int  PORT_NUM = C_PORT_NUM,
  parameter int  IPRIDX_W = C_IPRIDX_W,
  parameter int  ROBIDX_W = C_ROBIDX_W,
  parameter int  DATA_W   = C_DATA_W,
  localparam int SRC_W    = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_squash_vld,
  input  logic [ROBIDX_W-1:0]           i_squash_robIdx,
  input  logic [REQ_NUM-1:0]            i_req_vld,
  input  logic [REQ_NUM*IPRIDX_W-1:0]   i_req_iprd,
  input  logic [REQ_NUM*DATA_W-1:0]     i_req_data,
  input  logic [REQ_NUM*ROBIDX_W-1:0]   i_req_robIdx,
  output logic [REQ_NUM-1:0]            o_req_stall,
  output logic [PORT_NUM-1:0]           o_wb_vec,
  output logic [PORT_NUM*IPRIDX_W-1:0]  o_wb_iprd,
  output logic [PORT_NUM*DATA_W-1:0]    o_wb_data,
  output logic [PORT_NUM*SRC_W-1:0]     o_wb_src,
  output logic                          o_overflow
);

  logic [REQ_NUM-1:0]                 r_hold_vld;
  logic [REQ_NUM-1:0][IPRIDX_W-1:0]   r_hold_iprd;
  logic [REQ_NUM-1:0][DATA_W-1:0]     r_hold_data;
  logic [REQ_NUM-1:0][ROBIDX_W-1:0]   r_hold_rob;
  logic [SRC_W-1:0]                   r_rr_ptr;
  logic                               r_overflow;
  logic [PORT_NUM-1:0]                r_wb_vec;
  logic [PORT_NUM-1:0][IPRIDX_W-1:0]  r_wb_iprd;
  logic [PORT_NUM-1:0][DATA_W-1:0]    r_wb_data;
  logic [PORT_NUM-1:0][SRC_W-1:0]     r_wb_src;

  logic [REQ_NUM-1:0]                 w_live_ok;
  logic [REQ_NUM-1:0]                 w_cand_vld;
  logic [REQ_NUM-1:0]                 w_kill;
  logic [REQ_NUM-1:0][IPRIDX_W-1:0]   w_cand_iprd;
  logic [REQ_NUM-1:0][DATA_W-1:0]     w_cand_data;
  logic [REQ_NUM-1:0][ROBIDX_W-1:0]   w_cand_rob;
  logic [PORT_NUM-1:0]                w_port_vld;
  logic [PORT_NUM-1:0][SRC_W-1:0]     w_port_id;
  logic [REQ_NUM-1:0]                 w_granted;
  logic                               w_any_grant;
  logic [SRC_W-1:0]                   w_last_id;
  logic [SRC_W-1:0]                   w_rr_next;

  // A stalled requester's live input is ignored; the hold slot is its only candidate.
  assign w_live_ok  = i_req_vld & ~r_hold_vld;
  assign w_cand_vld = r_hold_vld | w_live_ok;

  for (genvar i = 0; i < REQ_NUM; i++) begin : g_cand
    assign w_cand_iprd[i] = r_hold_vld[i] ? r_hold_iprd[i] : i_req_iprd[i*IPRIDX_W +: IPRIDX_W];
    assign w_cand_data[i] = r_hold_vld[i] ? r_hold_data[i] : i_req_data[i*DATA_W +: DATA_W];
    assign w_cand_rob[i]  = r_hold_vld[i] ? r_hold_rob[i]  : i_req_robIdx[i*ROBIDX_W +: ROBIDX_W];
    assign w_kill[i] = i_squash_vld &&
                       rob_killed(w_cand_rob[i][ROBIDX_W-1],
                                  32'(w_cand_rob[i][ROBIDX_W-2:0]),
                                  i_squash_robIdx[ROBIDX_W-1],
                                  32'(i_squash_robIdx[ROBIDX_W-2:0]));
  end

  // Arbitration ignores squash; a killed winner simply leaves its port idle.
  wbarb_picker #(
    .REQ_NUM  (REQ_NUM),
    .PORT_NUM (PORT_NUM),
    .SRC_W    (SRC_W)
  ) u_picker (
    .i_req       (w_cand_vld),
    .i_held      (r_hold_vld),
    .i_rr_ptr    (r_rr_ptr),
    .o_port_vld  (w_port_vld),
    .o_port_id   (w_port_id),
    .o_granted   (w_granted),
    .o_any_grant (w_any_grant),
    .o_last_id   (w_last_id)
  );

  assign w_rr_next = (w_last_id == SRC_W'(REQ_NUM-1)) ? '0 : w_last_id + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold_vld <= '0;
      r_rr_ptr   <= '0;
      r_overflow <= 1'b0;
      r_wb_vec   <= '0;
    end else begin
      for (int i = 0; i < REQ_NUM; i++) begin
        if (r_hold_vld[i]) begin
          if (w_granted[i] || w_kill[i]) begin
            r_hold_vld[i] <= 1'b0;
          end
        end else if (w_live_ok[i] && !w_granted[i] && !w_kill[i]) begin
          r_hold_vld[i] <= 1'b1;
        end
      end
      if (|(i_req_vld & r_hold_vld)) begin
        r_overflow <= 1'b1;
      end
      if (w_any_grant) begin
        r_rr_ptr <= w_rr_next;
      end
      for (int k = 0; k < PORT_NUM; k++) begin
        r_wb_vec[k] <= w_port_vld[k] && !w_kill[w_port_id[k]];
      end
    end
  end

  // Payload registers carry no reset; they are qualified by the valid bits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < REQ_NUM; i++) begin
      if (w_live_ok[i]) begin
        r_hold_iprd[i] <= w_cand_iprd[i];
        r_hold_data[i] <= w_cand_data[i];
        r_hold_rob[i]  <= w_cand_rob[i];
      end
    end
    for (int k = 0; k < PORT_NUM; k++) begin
      r_wb_iprd[k] <= w_cand_iprd[w_port_id[k]];
      r_wb_data[k] <= w_cand_data[w_port_id[k]];
      r_wb_src[k]  <= w_port_id[k];
    end
  end

  for (genvar k = 0; k < PORT_NUM; k++) begin : g_port
    assign o_wb_iprd[k*IPRIDX_W +: IPRIDX_W] = r_wb_iprd[k];
    assign o_wb_data[k*DATA_W +: DATA_W]     = r_wb_data[k];
    assign o_wb_src[k*SRC_W +: SRC_W]        = r_wb_src[k];
  end

  assign o_wb_vec    = r_wb_vec;
  assign o_req_stall = r_hold_vld;
  assign o_overflow  = r_overflow;

endmodule

`default_nettype wire
